// File: rtl/fmul_issue_arbiter.sv
// rtl/fmul_issue_arbiter.sv - shares one FP multiply unit among NUM_REQ issue ports (option: FMUL_ARB_AGE_PRIO_EN = oldest-sqN grant)
module fmul_issue_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int SQN_W   = 7,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          IN_req_valid,
  output logic [NUM_REQ-1:0]          OUT_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   IN_req_srcA,
  input  logic [NUM_REQ*DATA_W-1:0]   IN_req_srcB,
  input  logic [NUM_REQ*3-1:0]        IN_req_rm,
  input  logic [NUM_REQ*TAG_W-1:0]    IN_req_tag,
  input  logic [NUM_REQ*SQN_W-1:0]    IN_req_sqN,
  input  logic [2:0]                  IN_fRoundMode,
  input  logic                        IN_branch_taken,
  input  logic [SQN_W-1:0]            IN_branch_sqN,
  input  logic                        IN_mul_ready,
  output logic                        OUT_mul_valid,
  output logic [DATA_W-1:0]           OUT_mul_srcA,
  output logic [DATA_W-1:0]           OUT_mul_srcB,
  output logic [2:0]                  OUT_mul_rm,
  output logic                        OUT_mul_illegal,
  output logic [TAG_W-1:0]            OUT_mul_tag,
  output logic [SQN_W-1:0]            OUT_mul_sqN,
  output logic [$clog2(NUM_REQ)-1:0]  OUT_mul_port
);
  localparam int PW = $clog2(NUM_REQ);

  // A is strictly younger than B when the wrapped difference is positive and non-zero.
  function automatic logic f_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  logic [NUM_REQ-1:0] r_buf_valid;
  logic [DATA_W-1:0]  r_buf_srcA [NUM_REQ];
  logic [DATA_W-1:0]  r_buf_srcB [NUM_REQ];
  logic [2:0]         r_buf_rm   [NUM_REQ];
  logic [TAG_W-1:0]   r_buf_tag  [NUM_REQ];
  logic [SQN_W-1:0]   r_buf_sqN  [NUM_REQ];

  logic               r_mul_valid;
  logic [DATA_W-1:0]  r_mul_srcA;
  logic [DATA_W-1:0]  r_mul_srcB;
  logic [2:0]         r_mul_rm;
  logic [TAG_W-1:0]   r_mul_tag;
  logic [SQN_W-1:0]   r_mul_sqN;
  logic [PW-1:0]      r_mul_port;
  logic [PW-1:0]      r_ptr;

  logic [NUM_REQ-1:0] w_buf_squash;
  logic [NUM_REQ-1:0] w_in_squash;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic [2:0]         w_rm_res [NUM_REQ];
  logic               w_issue_free;
  logic               w_iss_squash;
  logic               w_gnt_any;
  logic [PW-1:0]      w_gnt_idx;
  logic [PW-1:0]      w_ptr_nxt;
`ifdef FMUL_ARB_AGE_PRIO_EN
`else
  logic [PW:0]        w_idx;
`endif

  // Squash flags, grant candidates and dynamic rounding-mode resolution per port.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_buf_squash[i] = IN_branch_taken & f_younger(r_buf_sqN[i], IN_branch_sqN);
      w_in_squash[i]  = IN_branch_taken & f_younger(IN_req_sqN[i*SQN_W +: SQN_W], IN_branch_sqN);
      w_cand[i]       = r_buf_valid[i] & ~w_buf_squash[i];
      w_rm_res[i]     = (IN_req_rm[i*3 +: 3] == 3'b111) ? IN_fRoundMode : IN_req_rm[i*3 +: 3];
    end
  end

  assign w_issue_free = !r_mul_valid | IN_mul_ready;
  assign w_iss_squash = r_mul_valid & IN_branch_taken & f_younger(r_mul_sqN, IN_branch_sqN);

  // Select at most one candidate: round-robin from r_ptr, or oldest sqN when age priority is built in.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
`ifdef FMUL_ARB_AGE_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_cand[i] && (!w_gnt_any || f_younger(r_buf_sqN[w_gnt_idx], r_buf_sqN[i]))) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PW'(i);
      end
    end
`else
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_REQ)) w_idx = w_idx - (PW+1)'(NUM_REQ);
      if (!w_gnt_any && w_cand[w_idx[PW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx[PW-1:0];
      end
    end
`endif
    if (!w_issue_free) w_gnt_any = 1'b0;
    w_grant = '0;
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
    w_ptr_nxt = (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
  end

  // A buffer is free when empty or when it is being handed to the issue stage this cycle.
  assign OUT_req_ready = ~r_buf_valid | w_grant;

  // Holding buffers: capture on handshake (dropping flushed uops), clear on grant or squash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_buf_srcA[i] <= '0;
        r_buf_srcB[i] <= '0;
        r_buf_rm[i]   <= '0;
        r_buf_tag[i]  <= '0;
        r_buf_sqN[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IN_req_valid[i] && OUT_req_ready[i]) begin
          r_buf_valid[i] <= !w_in_squash[i];
          r_buf_srcA[i]  <= IN_req_srcA[i*DATA_W +: DATA_W];
          r_buf_srcB[i]  <= IN_req_srcB[i*DATA_W +: DATA_W];
          r_buf_rm[i]    <= w_rm_res[i];
          r_buf_tag[i]   <= IN_req_tag[i*TAG_W +: TAG_W];
          r_buf_sqN[i]   <= IN_req_sqN[i*SQN_W +: SQN_W];
        end else if (w_grant[i] || w_buf_squash[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Issue stage: load the granted uop when free, otherwise hold; a flushed uop is dropped either way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_valid <= 1'b0;
      r_mul_srcA  <= '0;
      r_mul_srcB  <= '0;
      r_mul_rm    <= '0;
      r_mul_tag   <= '0;
      r_mul_sqN   <= '0;
      r_mul_port  <= '0;
      r_ptr       <= '0;
    end else if (w_issue_free) begin
      if (w_gnt_any) begin
        r_mul_valid <= 1'b1;
        r_mul_srcA  <= r_buf_srcA[w_gnt_idx];
        r_mul_srcB  <= r_buf_srcB[w_gnt_idx];
        r_mul_rm    <= r_buf_rm[w_gnt_idx];
        r_mul_tag   <= r_buf_tag[w_gnt_idx];
        r_mul_sqN   <= r_buf_sqN[w_gnt_idx];
        r_mul_port  <= w_gnt_idx;
        r_ptr       <= w_ptr_nxt;
      end else begin
        r_mul_valid <= 1'b0;
      end
    end else if (w_iss_squash) begin
      r_mul_valid <= 1'b0;
    end
  end

  assign OUT_mul_valid   = r_mul_valid;
  assign OUT_mul_srcA    = r_mul_srcA;
  assign OUT_mul_srcB    = r_mul_srcB;
  assign OUT_mul_rm      = r_mul_rm;
  assign OUT_mul_illegal = (r_mul_rm >= 3'b101);
  assign OUT_mul_tag     = r_mul_tag;
  assign OUT_mul_sqN     = r_mul_sqN;
  assign OUT_mul_port    = r_mul_port;
endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// tb/tb_fmul_issue_arbiter.sv - self-checking bench for fmul_issue_arbiter
module tb_fmul_issue_arbiter;
  localparam int N  = 2;
  localparam int SW = 7;
  localparam int TW = 7;
  localparam int DW = 32;
  localparam int M  = 1 << SW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    IN_req_valid;
  logic [N-1:0]    OUT_req_ready;
  logic [N*DW-1:0] IN_req_srcA;
  logic [N*DW-1:0] IN_req_srcB;
  logic [N*3-1:0]  IN_req_rm;
  logic [N*TW-1:0] IN_req_tag;
  logic [N*SW-1:0] IN_req_sqN;
  logic [2:0]      IN_fRoundMode;
  logic            IN_branch_taken;
  logic [SW-1:0]   IN_branch_sqN;
  logic            IN_mul_ready;
  logic            OUT_mul_valid;
  logic [DW-1:0]   OUT_mul_srcA;
  logic [DW-1:0]   OUT_mul_srcB;
  logic [2:0]      OUT_mul_rm;
  logic            OUT_mul_illegal;
  logic [TW-1:0]   OUT_mul_tag;
  logic [SW-1:0]   OUT_mul_sqN;
  logic [0:0]      OUT_mul_port;

  always #5 clk = ~clk;

  fmul_issue_arbiter #(.NUM_REQ(N), .SQN_W(SW), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .IN_req_valid(IN_req_valid), .OUT_req_ready(OUT_req_ready),
    .IN_req_srcA(IN_req_srcA), .IN_req_srcB(IN_req_srcB), .IN_req_rm(IN_req_rm),
    .IN_req_tag(IN_req_tag), .IN_req_sqN(IN_req_sqN),
    .IN_fRoundMode(IN_fRoundMode), .IN_branch_taken(IN_branch_taken), .IN_branch_sqN(IN_branch_sqN),
    .IN_mul_ready(IN_mul_ready), .OUT_mul_valid(OUT_mul_valid),
    .OUT_mul_srcA(OUT_mul_srcA), .OUT_mul_srcB(OUT_mul_srcB), .OUT_mul_rm(OUT_mul_rm),
    .OUT_mul_illegal(OUT_mul_illegal), .OUT_mul_tag(OUT_mul_tag), .OUT_mul_sqN(OUT_mul_sqN),
    .OUT_mul_port(OUT_mul_port)
  );

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [6:0]  tag;
    logic [6:0]  sq;
    int          port;
  } uop_t;

  uop_t m_buf [N];
  uop_t m_iss;
  int   m_ptr;
  uop_t nb [N];
  uop_t ni;
  int   mg;
  logic [N-1:0] mrdy;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Modular age test: sq is after the branch when the forward distance is in (0, M/2).
  function automatic bit younger(input logic [6:0] sq);
    int d;
    if (!IN_branch_taken) return 1'b0;
    d = (int'(sq) - int'(IN_branch_sqN) + M) % M;
    return (d > 0) && (d < M / 2);
  endfunction

  function automatic bit issue_free();
    return !m_iss.v || IN_mul_ready;
  endfunction

  function automatic int pick();
    int best;
    best = -1;
    if (!issue_free()) return -1;
`ifdef FMUL_ARB_AGE_PRIO_EN
    for (int i = 0; i < N; i++)
      if (m_buf[i].v && !younger(m_buf[i].sq))
        if (best < 0 || ((int'(m_buf[i].sq) - int'(m_buf[best].sq) + M) % M) >= M / 2) best = i;
`else
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (best < 0 && m_buf[idx].v && !younger(m_buf[idx].sq)) best = idx;
    end
`endif
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    g = pick();
    for (int i = 0; i < N; i++) r[i] = !m_buf[i].v || (g == i);
    return r;
  endfunction

  // Reference model: advances one clock using the architectural rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_buf[i] = '{0, 0, 0, 0, 0, 0, 0};
      m_iss = '{0, 0, 0, 0, 0, 0, 0};
      m_ptr = 0;
    end else begin
      mg   = pick();
      mrdy = exp_ready();
      nb   = m_buf;
      ni   = m_iss;
      if (issue_free()) begin
        if (mg >= 0) begin
          ni = m_buf[mg];
          ni.port = mg;
        end else begin
          ni.v = 0;
        end
      end else if (younger(m_iss.sq)) begin
        ni.v = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (IN_req_valid[i] && mrdy[i]) begin
          nb[i].v   = !younger(IN_req_sqN[i*SW +: SW]);
          nb[i].a   = IN_req_srcA[i*DW +: DW];
          nb[i].b   = IN_req_srcB[i*DW +: DW];
          nb[i].rm  = (IN_req_rm[i*3 +: 3] == 3'b111) ? IN_fRoundMode : IN_req_rm[i*3 +: 3];
          nb[i].tag = IN_req_tag[i*TW +: TW];
          nb[i].sq  = IN_req_sqN[i*SW +: SW];
        end else if (mg == i || younger(m_buf[i].sq)) begin
          nb[i].v = 0;
        end
      end
      if (issue_free() && mg >= 0) m_ptr = (mg + 1) % N;
      m_buf = nb;
      m_iss = ni;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_valid", 64'(OUT_mul_valid), 64'(m_iss.v));
      if (m_iss.v) begin
        chk("mdl_srcA", 64'(OUT_mul_srcA), 64'(m_iss.a));
        chk("mdl_srcB", 64'(OUT_mul_srcB), 64'(m_iss.b));
        chk("mdl_rm", 64'(OUT_mul_rm), 64'(m_iss.rm));
        chk("mdl_illegal", 64'(OUT_mul_illegal), 64'(m_iss.rm >= 3'b101));
        chk("mdl_tag", 64'(OUT_mul_tag), 64'(m_iss.tag));
        chk("mdl_sqN", 64'(OUT_mul_sqN), 64'(m_iss.sq));
        chk("mdl_port", 64'(OUT_mul_port), 64'(m_iss.port));
      end
      chk("mdl_ready", 64'(OUT_req_ready), 64'(exp_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                     input logic [6:0] tag, input logic [6:0] sq);
    IN_req_valid[p]        = 1'b1;
    IN_req_srcA[p*DW +: DW] = a;
    IN_req_srcB[p*DW +: DW] = b;
    IN_req_rm[p*3 +: 3]    = rm;
    IN_req_tag[p*TW +: TW] = tag;
    IN_req_sqN[p*SW +: SW] = sq;
  endtask

  task automatic put_seq(input int p, input logic [6:0] sq);
    put(p, 32'h1000 + 32'(sq), 32'h2000 + 32'(sq), 3'(sq % 8), 7'(sq + 1), sq);
  endtask

  initial begin
    int s0, s1, issued, prev, first, nv;
    logic [N-1:0] rdy;
    bit seen [M];
    IN_req_valid = '0; IN_req_srcA = '0; IN_req_srcB = '0; IN_req_rm = '0;
    IN_req_tag = '0; IN_req_sqN = '0; IN_fRoundMode = 3'b000;
    IN_branch_taken = 1'b0; IN_branch_sqN = '0; IN_mul_ready = 1'b0;
    for (int i = 0; i < M; i++) seen[i] = 0;

    // reset
    @(posedge clk);
    #1 cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_ready", 64'(OUT_req_ready), 64'h3);
    chk("rst_valid", 64'(OUT_mul_valid), 64'h0);
    chk("rst_srcA", 64'(OUT_mul_srcA), 64'h0);
    chk("rst_port", 64'(OUT_mul_port), 64'h0);

    // single uop
    IN_mul_ready = 1'b1;
    put(0, 32'h3F800000, 32'h40000000, 3'b000, 7'd5, 7'd10);
    tick();
    IN_req_valid = '0;
    chk("single_latency", 64'(OUT_mul_valid), 64'h0);
    tick();
    chk("single_valid", 64'(OUT_mul_valid), 64'h1);
    chk("single_srcA", 64'(OUT_mul_srcA), 64'h3F800000);
    chk("single_srcB", 64'(OUT_mul_srcB), 64'h40000000);
    chk("single_tag", 64'(OUT_mul_tag), 64'd5);
    chk("single_sqN", 64'(OUT_mul_sqN), 64'd10);
    chk("single_port", 64'(OUT_mul_port), 64'd0);
    tick();
    chk("single_gone", 64'(OUT_mul_valid), 64'h0);

    // contention: both ports valid every cycle
    s0 = 20; s1 = 21; issued = 0; prev = -1; first = -1;
    for (int c = 0; c < 200 && issued < 20; c++) begin
      put_seq(0, 7'(s0));
      put_seq(1, 7'(s1));
      rdy = exp_ready();
      tick();
      if (rdy[0]) s0 += 2;
      if (rdy[1]) s1 += 2;
      if (OUT_mul_valid) begin
        issued++;
        chk("cont_dup", 64'(seen[OUT_mul_sqN]), 64'h0);
        seen[OUT_mul_sqN] = 1;
        if (prev >= 0) chk("cont_alt", 64'(OUT_mul_port), 64'(prev ^ 1));
        else first = int'(OUT_mul_port);
        prev = int'(OUT_mul_port);
      end
    end
    chk("cont_count", 64'(issued), 64'd20);
    chk("cont_first_port", 64'(first), 64'd1);
    IN_req_valid = '0;
    repeat (4) tick();

    // backpressure with both buffers and the issue stage full
    IN_mul_ready = 1'b0;
    put_seq(0, 7'd70);
    put_seq(1, 7'd71);
    tick();
    put_seq(0, 7'd72);
    put_seq(1, 7'd73);
    tick();
    IN_req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", 64'(OUT_req_ready), 64'h0);
      chk("bp_valid", 64'(OUT_mul_valid), 64'h1);
      tick();
    end
    IN_mul_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      if (OUT_mul_valid) nv++;
      tick();
    end
    chk("bp_drain", 64'(nv), 64'd3);

    // rounding-mode resolution and illegal detection
    IN_fRoundMode = 3'b010;
    put(0, 32'h1, 32'h2, 3'b111, 7'd1, 7'd80);
    tick();
    IN_req_valid = '0;
    IN_fRoundMode = 3'b001;
    tick();
    chk("rm_dyn", 64'(OUT_mul_rm), 64'h2);
    chk("rm_dyn_legal", 64'(OUT_mul_illegal), 64'h0);
    put(1, 32'h3, 32'h4, 3'b110, 7'd2, 7'd81);
    tick();
    IN_req_valid = '0;
    tick();
    chk("rm_110", 64'(OUT_mul_rm), 64'h6);
    chk("rm_110_illegal", 64'(OUT_mul_illegal), 64'h1);
    put(0, 32'h5, 32'h6, 3'b101, 7'd3, 7'd82);
    tick();
    IN_req_valid = '0;
    tick();
    chk("rm_101_illegal", 64'(OUT_mul_illegal), 64'h1);
    put(0, 32'h7, 32'h8, 3'b100, 7'd4, 7'd83);
    tick();
    IN_req_valid = '0;
    tick();
    chk("rm_100_legal", 64'(OUT_mul_illegal), 64'h0);
    tick();

    // branch flush: buffers 12 and 15, issue stage 14, branch 13
    IN_mul_ready = 1'b0;
    put_seq(0, 7'd14);
    tick();
    IN_req_valid = '0;
    tick();
    chk("fl_stage14", 64'(OUT_mul_sqN), 64'd14);
    put_seq(0, 7'd12);
    put_seq(1, 7'd15);
    tick();
    IN_req_valid = '0;
    IN_branch_taken = 1'b1;
    IN_branch_sqN = 7'd13;
    tick();
    IN_branch_taken = 1'b0;
    chk("fl_stage_dropped", 64'(OUT_mul_valid), 64'h0);
    IN_mul_ready = 1'b1;
    tick();
    chk("fl_12_valid", 64'(OUT_mul_valid), 64'h1);
    chk("fl_12_sqN", 64'(OUT_mul_sqN), 64'd12);
    tick();
    chk("fl_15_dropped", 64'(OUT_mul_valid), 64'h0);

    // wrap-around squash: branch 126, buffered sqN 1
    put_seq(1, 7'd1);
    tick();
    IN_req_valid = '0;
    IN_branch_taken = 1'b1;
    IN_branch_sqN = 7'd126;
    tick();
    IN_branch_taken = 1'b0;
    chk("wrap_no_issue", 64'(OUT_mul_valid), 64'h0);
    tick();
    chk("wrap_squashed", 64'(OUT_mul_valid), 64'h0);

    // equal sqN is never squashed
    put_seq(0, 7'd50);
    IN_branch_taken = 1'b1;
    IN_branch_sqN = 7'd50;
    tick();
    IN_branch_taken = 1'b0;
    IN_req_valid = '0;
    tick();
    chk("eq_valid", 64'(OUT_mul_valid), 64'h1);
    chk("eq_sqN", 64'(OUT_mul_sqN), 64'd50);

    // younger incoming uop is acknowledged but dropped
    put_seq(0, 7'd60);
    IN_branch_taken = 1'b1;
    IN_branch_sqN = 7'd55;
    chk("insq_ready", 64'(OUT_req_ready[0]), 64'h1);
    tick();
    IN_branch_taken = 1'b0;
    IN_req_valid = '0;
    tick();
    chk("insq_dropped", 64'(OUT_mul_valid), 64'h0);

    // asynchronous reset mid-stream
    put_seq(0, 7'd90);
    put_seq(1, 7'd91);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(OUT_mul_valid), 64'h0);
    chk("arst_srcA", 64'(OUT_mul_srcA), 64'h0);
    IN_req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    put_seq(0, 7'd100);
    put_seq(1, 7'd101);
    tick();
    IN_req_valid = '0;
    tick();
    chk("arst_first_port", 64'(OUT_mul_port), 64'd0);
    chk("arst_first_sqN", 64'(OUT_mul_sqN), 64'd100);
    tick();
    chk("arst_second_port", 64'(OUT_mul_port), 64'd1);
    chk("arst_second_sqN", 64'(OUT_mul_sqN), 64'd101);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
